btn_conditioner: RTL



---
 rtl/btn_pkg.sv | 17 +
 rtl/btn_debounce_ch.sv | 80 ++++++++
 rtl/btn_conditioner.sv | 32 +++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button conditioning front end.
package btn_pkg;

  localparam int CLK_FREQ_HZ        = 100_000_000;
  localparam int DEB_CYCLES_DFLT    = 1_000_000;   // 10 ms at CLK_FREQ_HZ
  localparam int REPEAT_DELAY_DFLT  = 50_000_000;
  localparam int REPEAT_PERIOD_DFLT = 10_000_000;

  localparam int BTN_ENTER = 0;
  localparam int BTN_SIGN  = 1;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter, level/pulse regs.
// Auto-repeat pulses are built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES    = DEB_CYCLES_DFLT,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DFLT,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int            CW       = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("btn_debounce_ch: illegal parameter value");
  end

  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic          accept, press;

  // The counter only runs while s2 disagrees with the level, so it can never
  // pass CNT_LAST: reaching it either flips the level or gets cleared.
  assign accept = (s2 != btn_level) && (cnt == CNT_LAST);
  assign press  = accept && s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      cnt       <= '0;
      btn_level <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
      if (s2 == btn_level || accept) cnt <= '0;
      else                           cnt <= cnt + 1'b1;
      if (accept) btn_level <= s2;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_first;
  logic          rpt_hit;

  // rpt_cnt counts edges since the last emitted pulse; no repeat on a release edge.
  assign rpt_hit = btn_level && !accept && (rpt_cnt == (rpt_first ? RPT_FIRST : RPT_NEXT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
      btn_pulse <= 1'b0;
    end else begin
      btn_pulse <= press | rpt_hit;
      if (press || rpt_hit || !btn_level) rpt_cnt <= '0;
      else                                rpt_cnt <= rpt_cnt + 1'b1;
      if (press || !btn_level) rpt_first <= 1'b1;
      else if (rpt_hit)        rpt_first <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_pulse <= 1'b0;
    else        btn_pulse <= press;
  end
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: N_BTN independent debounce channels, wiring only.
// Optional auto-repeat pulses are enabled with BTN_AUTOREPEAT_EN.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN         = 2,
  parameter int DEB_CYCLES    = DEB_CYCLES_DFLT,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DFLT,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_in   (btn_in[i]),
      .btn_level(btn_level[i]),
      .btn_pulse(btn_pulse[i])
    );
  end

endmodule
